// File: rtl/alu_param.sv
// Parametrised sequential ALU: add, sub, radix-4 Booth multiply and
// non-restoring divide, with operands and results streamed over shared buses.
module alu_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BEGIN,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             END,
    output logic             busy,
    output logic             ovf
);

    localparam int AW = WIDTH + 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Word 0 is captured on the accepting IDLE cycle, so LOAD0 is never entered.
    typedef enum logic [3:0] {
        IDLE, LOAD0, LOAD1, LOAD2, CHECK, ITER, CORR, OUT_HI, OUT_LO
    } state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic             ovf_q;

    logic [AW-1:0]    m_s, m_u, booth, a_sh, add_x, add_y, sum;
    logic [CNT_W-1:0] cnt_nx;
    logic             exc, as_ovf, m_sign;

    assign m_s    = {{2{m[WIDTH-1]}}, m};
    assign m_u    = {2'b00, m};
    assign a_sh   = {a[AW-2:0], q[WIDTH-1]};
    assign cnt_nx = cnt + 1'b1;
    assign exc    = (m == '0) || (a[WIDTH-1:0] >= m);
    assign m_sign = op[0] ? ~m[WIDTH-1] : m[WIDTH-1];
    assign as_ovf = (a[WIDTH-1] == m_sign) && (sum[WIDTH-1] != a[WIDTH-1]);

    // Booth recoding of the low multiplier pair plus the guard bit
    always_comb begin
        booth = '0;
        case ({q[1:0], q_m1})
            3'b001, 3'b010: booth = m_s;
            3'b011:         booth = m_s << 1;
            3'b100:         booth = -(m_s << 1);
            3'b101, 3'b110: booth = -m_s;
            default:        booth = '0;
        endcase
    end

    // Shared WIDTH+2 adder, operands steered by state and operation
    always_comb begin
        add_x = a;
        add_y = (op == OP_SUB) ? -m_s : m_s;
        if (state == ITER && op == OP_MUL) begin
            add_y = booth;
        end else if ((state == ITER || state == CHECK) && op == OP_DIV) begin
            add_x = a_sh;
            add_y = a[AW-1] ? m_u : -m_u;
        end else if (state == CORR) begin
            add_y = m_u;
        end
        sum = add_x + add_y;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and result bus drive
    always_comb begin
        state_nx  = state;
        outbus    = '0;
        out_valid = 1'b0;
        END       = 1'b0;
        busy      = (state != IDLE);
        ovf       = ovf_q;
        case (state)
            IDLE:   if (BEGIN) state_nx = LOAD1;
            LOAD1:  state_nx = (op == OP_DIV) ? LOAD2 : ITER;
            LOAD2:  state_nx = CHECK;
            CHECK: begin
                if (exc) begin
                    state_nx  = OUT_LO;
                    outbus    = a[WIDTH-1:0];
                    out_valid = 1'b1;
                    ovf       = 1'b1;
                end else begin
                    state_nx = ITER;
                end
            end
            ITER: begin
                if (op == OP_MUL) begin
                    if (cnt_nx == CNT_W'(WIDTH / 2)) state_nx = OUT_HI;
                end else if (op == OP_DIV) begin
                    if (cnt_nx == CNT_W'(WIDTH)) state_nx = CORR;
                end else begin
                    state_nx = OUT_HI;
                end
            end
            CORR:   state_nx = OUT_HI;
            OUT_HI: begin
                state_nx  = op[1] ? OUT_LO : IDLE;
                outbus    = a[WIDTH-1:0];
                out_valid = 1'b1;
                END       = ~op[1];
            end
            OUT_LO: begin
                state_nx  = IDLE;
                outbus    = q;
                out_valid = 1'b1;
                END       = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: operand load, iteration and correction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            m     <= '0;
            cnt   <= '0;
            op    <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (BEGIN) begin
                        op    <= op_code;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                        q_m1  <= 1'b0;
                        if (op_code == OP_MUL) begin
                            q <= inbus;
                            a <= '0;
                        end else if (op_code == OP_DIV) begin
                            a <= {2'b00, inbus};
                        end else begin
                            a <= {{2{inbus[WIDTH-1]}}, inbus};
                        end
                    end
                end
                LOAD1: begin
                    if (op == OP_DIV) q <= inbus;
                    else              m <= inbus;
                end
                LOAD2: m <= inbus;
                CHECK: begin
                    if (exc) begin
                        ovf_q <= 1'b1;
                        q     <= '1;
                    end else begin
                        a   <= sum;
                        q   <= {q[WIDTH-2:0], ~sum[AW-1]};
                        cnt <= cnt_nx;
                    end
                end
                ITER: begin
                    if (op == OP_MUL) begin
                        a    <= {{2{sum[AW-1]}}, sum[AW-1:2]};
                        q    <= {sum[1:0], q[WIDTH-1:2]};
                        q_m1 <= q[1];
                        cnt  <= cnt_nx;
                    end else if (op == OP_DIV) begin
                        a   <= sum;
                        q   <= {q[WIDTH-2:0], ~sum[AW-1]};
                        cnt <= cnt_nx;
                    end else begin
                        a     <= sum;
                        ovf_q <= as_ovf;
                    end
                end
                CORR: if (a[AW-1]) a <= sum;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_param.sv
// Bench for alu_param: 8-bit and 16-bit instances checked every cycle
// against an arithmetic reference model, plus literal spot checks.
module tb_alu_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int nxt   = 0;

    logic       rst8, beg8, v8, e8, b8, o8;
    logic [1:0] op8;
    logic [7:0] in8, out8;

    logic        rst16, beg16, v16, e16, b16, o16;
    logic [1:0]  op16;
    logic [15:0] in16, out16;

    alu_param #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst8), .BEGIN(beg8), .op_code(op8),
        .inbus(in8), .outbus(out8), .out_valid(v8), .END(e8),
        .busy(b8), .ovf(o8)
    );

    alu_param #(.WIDTH(16)) u16 (
        .clk(clk), .reset(rst16), .BEGIN(beg16), .op_code(op16),
        .inbus(in16), .outbus(out16), .out_valid(v16), .END(e16),
        .busy(b16), .ovf(o16)
    );

    // expectations keyed by cycle*2+instance
    logic [15:0] exp_w [int];
    bit          exp_e [int];
    int busy_lo [2] = '{1, 1};
    int busy_hi [2] = '{0, 0};
    int ot      [2] = '{-100, -100};
    int olat    [2] = '{0, 0};
    bit oprev   [2] = '{1'b0, 1'b0};
    bit oval    [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input int i,
                       input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h",
                     nm, i, cyc, act, want);
        end
    endtask

    task automatic sample(input int i, output logic [15:0] ob,
                          output logic v, e, b, o);
        if (i == 0) begin
            ob = 16'(out8); v = v8; e = e8; b = b8; o = o8;
        end else begin
            ob = out16; v = v16; e = e16; b = b16; o = o16;
        end
    endtask

    function automatic bit ovf_at(input int i, input int c);
        if (c <= ot[i]) return oprev[i];
        if (c < ot[i] + olat[i]) return 1'b0;
        return oval[i];
    endfunction

    function automatic longint sx(input logic [15:0] v, input int wd);
        longint full, r;
        full = longint'(1) << wd;
        r = longint'(v) & (full - 1);
        if (r >= full / 2) r -= full;
        return r;
    endfunction

    // Reference: result words, first-word offset from BEGIN, word count, ovf
    function automatic void model(input int wd, input logic [1:0] op,
                                  input logic [15:0] x, y, z,
                                  output logic [15:0] w0, w1,
                                  output int nw, output int lat,
                                  output bit ov);
        longint full, mask, s, ah, al, mm, d;
        full = longint'(1) << wd;
        mask = full - 1;
        w0 = '0; w1 = '0; ov = 1'b0; nw = 2; lat = 3;
        if (op == 2'd0 || op == 2'd1) begin
            s  = (op == 2'd0) ? sx(x, wd) + sx(y, wd) : sx(x, wd) - sx(y, wd);
            w0 = 16'(s & mask);
            ov = (s >= full / 2) || (s < -(full / 2));
            nw = 1;
        end else if (op == 2'd2) begin
            s   = sx(x, wd) * sx(y, wd);
            w0  = 16'((s >> wd) & mask);
            w1  = 16'(s & mask);
            lat = 2 + wd / 2;
        end else begin
            ah = longint'(x) & mask;
            al = longint'(y) & mask;
            mm = longint'(z) & mask;
            if (mm == 0 || ah >= mm) begin
                w0 = 16'(ah);
                w1 = 16'(mask);
                ov = 1'b1;
            end else begin
                d   = (ah << wd) | al;
                w0  = 16'(d % mm);
                w1  = 16'(d / mm);
                lat = 4 + wd;
            end
        end
    endfunction

    // Every-cycle comparison of both instances against the schedule
    always @(negedge clk) begin
        logic [15:0] ob;
        logic v, e, b, o;
        int k;
        for (int i = 0; i < 2; i++) begin
            sample(i, ob, v, e, b, o);
            k = cyc * 2 + i;
            if (exp_w.exists(k)) begin
                chk("valid", i, 16'(v), 16'd1);
                chk("word", i, ob, exp_w[k]);
                chk("end", i, 16'(e), 16'(exp_e[k]));
            end else begin
                chk("idle_valid", i, 16'(v), 16'd0);
                chk("idle_end", i, 16'(e), 16'd0);
                chk("idle_word", i, ob, 16'd0);
            end
            chk("busy", i, 16'(b),
                16'(cyc >= busy_lo[i] && cyc <= busy_hi[i]));
            chk("ovf", i, 16'(o), 16'(ovf_at(i, cyc)));
        end
    end

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input int i, input logic b, input logic [1:0] op,
                       input logic [15:0] w);
        if (i == 0) begin
            beg8 = b; op8 = op; in8 = w[7:0];
        end else begin
            beg16 = b; op16 = op; in16 = w;
        end
    endtask

    task automatic run_op(input int i, input logic [1:0] op,
                          input logic [15:0] x, y, z);
        int wd, nw, lat, t;
        logic [15:0] w0, w1;
        bit ov;
        wd = (i == 0) ? 8 : 16;
        at(nxt);
        t = cyc;
        model(wd, op, x, y, z, w0, w1, nw, lat, ov);
        oprev[i]   = ovf_at(i, t);
        ot[i]      = t;
        olat[i]    = lat;
        oval[i]    = ov;
        busy_lo[i] = t + 1;
        busy_hi[i] = t + lat + nw - 1;
        exp_w[(t + lat) * 2 + i] = w0;
        exp_e[(t + lat) * 2 + i] = (nw == 1);
        if (nw == 2) begin
            exp_w[(t + lat + 1) * 2 + i] = w1;
            exp_e[(t + lat + 1) * 2 + i] = 1'b1;
        end
        drv(i, 1'b1, op, x);
        at(t + 1);
        drv(i, 1'b0, 2'($urandom), y);
        at(t + 2);
        drv(i, 1'b0, 2'($urandom), z);
        at(t + 3);
        drv(i, 1'b0, 2'($urandom), 16'($urandom));
        nxt = t + lat + nw;
    endtask

    task automatic peek(input int i, input int c, input string nm,
                        input logic [15:0] w, input logic e, input logic o);
        logic [15:0] ob;
        logic v, ee, b, oo;
        at(c);
        @(negedge clk);
        sample(i, ob, v, ee, b, oo);
        chk({nm, "_valid"}, i, 16'(v), 16'd1);
        chk({nm, "_word"}, i, ob, w);
        chk({nm, "_end"}, i, 16'(ee), 16'(e));
        chk({nm, "_ovf"}, i, 16'(oo), 16'(o));
        @(posedge clk);
        #1;
    endtask

    task automatic purge(input int i);
        for (int c = cyc; c < cyc + 64; c++) begin
            if (exp_w.exists(c * 2 + i)) begin
                exp_w.delete(c * 2 + i);
                exp_e.delete(c * 2 + i);
            end
        end
        busy_hi[i] = cyc - 1;
        ot[i]      = -100;
        olat[i]    = 0;
        oprev[i]   = 1'b0;
        oval[i]    = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w0, w1, ob, m16;
        logic v, e, b, o;
        int nw, lat;
        bit ov;

        rst8 = 1'b0;
        rst16 = 1'b0;
        drv(0, 1'b0, 2'd0, 16'd0);
        drv(1, 1'b0, 2'd0, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample(0, ob, v, e, b, o);
        chk("rst_word", 0, ob, 16'd0);
        chk("rst_valid", 0, 16'(v), 16'd0);
        chk("rst_busy", 0, 16'(b), 16'd0);
        chk("rst_ovf", 0, 16'(o), 16'd0);
        @(posedge clk);
        #1;
        rst8 = 1'b1;
        rst16 = 1'b1;
        nxt = cyc + 1;

        model(8, 2'd2, 16'h07, 16'hFD, 16'h0, w0, w1, nw, lat, ov);
        chk("pin_mul_hi", 0, w0, 16'hFF);
        chk("pin_mul_lo", 0, w1, 16'hEB);
        model(8, 2'd3, 16'h00, 16'h64, 16'h07, w0, w1, nw, lat, ov);
        chk("pin_div_rem", 0, w0, 16'h02);
        chk("pin_div_quo", 0, w1, 16'h0E);
        chk("pin_div_lat", 0, 16'(lat), 16'd12);
        model(16, 2'd2, 16'h0003, 16'hFFFE, 16'h0, w0, w1, nw, lat, ov);
        chk("pin_mul16_lo", 1, w1, 16'hFFFA);
        chk("pin_mul16_lat", 1, 16'(lat), 16'd10);

        run_op(0, 2'd0, 16'h64, 16'h32, 16'h0);
        peek(0, nxt - 1, "add", 16'h96, 1'b1, 1'b1);
        run_op(0, 2'd1, 16'h05, 16'h07, 16'h0);
        peek(0, nxt - 1, "sub", 16'hFE, 1'b1, 1'b0);
        run_op(0, 2'd2, 16'h07, 16'hFD, 16'h0);
        peek(0, nxt - 2, "mul_hi", 16'hFF, 1'b0, 1'b0);
        peek(0, nxt - 1, "mul_lo", 16'hEB, 1'b1, 1'b0);
        run_op(0, 2'd2, 16'h80, 16'h80, 16'h0);
        peek(0, nxt - 2, "mulmin_hi", 16'h40, 1'b0, 1'b0);
        peek(0, nxt - 1, "mulmin_lo", 16'h00, 1'b1, 1'b0);
        run_op(0, 2'd3, 16'h00, 16'h64, 16'h07);
        peek(0, nxt - 2, "div_rem", 16'h02, 1'b0, 1'b0);
        peek(0, nxt - 1, "div_quo", 16'h0E, 1'b1, 1'b0);
        run_op(0, 2'd3, 16'h00, 16'h33, 16'h00);
        peek(0, nxt - 2, "div0_hi", 16'h00, 1'b0, 1'b1);
        peek(0, nxt - 1, "div0_lo", 16'hFF, 1'b1, 1'b1);
        run_op(0, 2'd3, 16'h20, 16'h11, 16'h10);

        run_op(0, 2'd2, 16'h13, 16'hF6, 16'h0);
        drv(0, 1'b1, 2'd0, 16'h5A);
        at(cyc + 2);
        drv(0, 1'b0, 2'd0, 16'h00);
        peek(0, nxt - 2, "busybeg_hi", 16'hFF, 1'b0, 1'b0);
        peek(0, nxt - 1, "busybeg_lo", 16'h42, 1'b1, 1'b0);

        run_op(0, 2'd2, 16'h55, 16'h66, 16'h0);
        rst8 = 1'b0;
        purge(0);
        @(negedge clk);
        sample(0, ob, v, e, b, o);
        chk("abort_word", 0, ob, 16'd0);
        chk("abort_valid", 0, 16'(v), 16'd0);
        chk("abort_busy", 0, 16'(b), 16'd0);
        @(posedge clk);
        #1;
        rst8 = 1'b1;
        nxt = cyc + 1;
        run_op(0, 2'd0, 16'h7F, 16'h01, 16'h0);
        peek(0, nxt - 1, "fresh_add", 16'h80, 1'b1, 1'b1);

        run_op(0, 2'd0, 16'h64, 16'h32, 16'h0);
        run_op(0, 2'd1, 16'h05, 16'h07, 16'h0);
        run_op(0, 2'd3, 16'h00, 16'h00, 16'h00);
        run_op(0, 2'd2, 16'hF0, 16'h0F, 16'h0);

        repeat (150) begin
            run_op(0, 2'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom));
        end

        repeat (500) begin
            run_op(1, 2'd2, 16'($urandom), 16'($urandom), 16'h0);
            m16 = 16'($urandom_range(1, 65535));
            run_op(1, 2'd3, 16'($urandom % m16), 16'($urandom), m16);
        end

        at(nxt + 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
